tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Multi-channel periodic/one-shot tick scheduler built on one shared base prescaler.
- Replaces multiple independent free-running dividers with one prescaler plus per-channel programmable reload counters.
- Emits single-cycle enable pulses (tick_out) for downstream logic: display refresh, debounce sampling, game/timer logic.
- Channels are configured through a valid/ready write port.

Parameters:
- PRESCALE, 50_000: clk cycles per base tick; must be ≥ 2.
- NUM_CH, 4: number of channels, 1..8.
- CNT_W, 16: width of per-channel period and counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  prescaler advance enable; when low, everything holds.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  scheduler can accept a write this cycle.
- cfg_ch  input  3  target channel index; only the low bits used, indices ≥ NUM_CH are ignored.
- cfg_period  input  CNT_W  period in base ticks.
- cfg_oneshot  input  1  0 = periodic, 1 = one-shot.
- cfg_start  input  1  1 = start/restart channel, 0 = stop channel.
- base_tick  output  1  one-cycle pulse per prescaler wrap.
- ch_active  output  NUM_CH  per-channel RUN state.
- tick_out  output  NUM_CH  per-channel one-cycle tick pulse.

Behaviour:
- Reset: all of the following are cleared.
  - prescaler = 0, base_tick = 0, tick_out = 0, ch_active = 0.
  - All channels IDLE, counters = 0, period/mode registers = 0.
  - cfg_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts every channel. No tick is emitted in the reset cycle or the cycle after.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable = 1; holds while enable = 0.
  - When count == PRESCALE-1 and enable = 1: count wraps to 0 and base_tick = 1 in the same cycle (combinational from registered state).
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready at a clk edge.
  - cfg_ready goes 0 for exactly the next cycle, then returns to 1. Maximum rate is one write per 2 cycles.
  - cfg_valid while cfg_ready = 0 is ignored; the master must hold it.
  - Writes to an index ≥ NUM_CH are accepted (ready drops) but change nothing.
- Channel FSM, states IDLE and RUN:
  - IDLE → RUN: accepted write with cfg_start = 1 and cfg_period ≠ 0. Latches period and mode, loads counter = cfg_period-1.
  - Any → IDLE: accepted write with cfg_start = 0, or with cfg_period = 0 (zero period is a stop). Counter cleared, no tick.
  - RUN → RUN restart: accepted write with cfg_start = 1 reloads counter; the pending count is discarded.
  - In RUN, on each base_tick:
    - counter ≠ 0: decrement.
    - counter == 0: fire, then reload period-1 (periodic) or go IDLE (one-shot).
- Fire: tick_out[i] = 1 for exactly the one clk cycle after the base_tick cycle in which the channel fired. Latency is 1 cycle from base_tick.
- Simultaneous accepted write and base_tick on the same channel: the write wins. Counter is loaded, no decrement, no fire.
  - Other channels process the base_tick normally.
- Period 1: fires on every base_tick. Period N: ticks every N·PRESCALE clk cycles.
- One-shot: the first tick comes N base ticks after start. ch_active clears in the same edge that registers tick_out.
- enable = 0: prescaler, counters and FSMs hold; config writes are still accepted.
- Counter arithmetic: unsigned CNT_W. Never decrements below 0. Period 2^CNT_W-1 is legal.

Optional Feature:
- Macro: TICK_SCHED_TOGGLE_EN.
- Defined: adds output clk_out [NUM_CH-1:0], registered, reset to 0.
  - Each bit toggles on every tick_out pulse of its channel, giving a 50% square wave of period 2·N·PRESCALE clk.
  - A stop/zero-period write forces the bit to 0.
- Undefined: port and its registers do not exist; all other behaviour is identical.

Test Plan (PRESCALE = 4, NUM_CH = 4, CNT_W = 8):
- Reset, enable = 1, no writes → base_tick every 4 cycles starting at cycle 4; tick_out = 0, ch_active = 0 throughout.
- Write ch0 period = 3 periodic start → ch_active[0] = 1; tick_out[0] pulses 1 cycle after every 3rd base_tick (every 12 cycles); cfg_ready low exactly 1 cycle after acceptance.
- Write ch1 period = 2 one-shot → exactly one tick_out[1] pulse, 1 cycle after the 2nd base_tick; ch_active[1] = 0 thereafter.
- Restart ch0 timed on a base_tick cycle in which ch0 would fire → no tick_out[0] from that base_tick; next pulse follows 3 base_ticks later.
- Write ch2 period = 0 start = 1, write ch5 (invalid), and back-to-back cfg_valid → ch2 stays IDLE; ch5 write has no effect; second write is accepted only 2 cycles after the first.
- Drop enable for 10 cycles mid-count, then assert reset during ch0 RUN → ticks delayed by exactly 10 cycles; after reset all outputs 0.
- With TICK_SCHED_TOGGLE_EN: clk_out[0] toggles on every tick_out[0]; period = 24 cycles for period = 3.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Configuration write port of tick_scheduler.
// Handshake: a write transfers on a clk edge where cfg_valid && cfg_ready; while cfg_ready is low the master holds cfg_valid and the payload stable.
interface tick_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_oneshot;
    logic             cfg_start;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_oneshot, cfg_start,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_oneshot, cfg_start,
        output cfg_ready
    );
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel periodic/one-shot tick scheduler driven by one shared base prescaler.
// Optional: define TICK_SCHED_TOGGLE_EN to add clk_out, a per-channel square wave toggled by each tick.
module tick_scheduler #(
    parameter int PRESCALE = 50_000,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    tick_scheduler_if.slave   cfg,
    output logic              base_tick,
    output logic [NUM_CH-1:0] ch_active,
    output logic [NUM_CH-1:0] tick_out
`ifdef TICK_SCHED_TOGGLE_EN
    ,
    output logic [NUM_CH-1:0] clk_out
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    logic [PW-1:0]     presc_q, presc_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              cfg_fire;
    ch_state_e         state_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [NUM_CH-1:0] oneshot_q;
    logic [NUM_CH-1:0] tick_q;
`ifdef TICK_SCHED_TOGGLE_EN
    logic [NUM_CH-1:0] toggle_q;
`endif

    // base_tick is decoded from the registered prescaler so channels see it in the wrap cycle.
    always_comb begin
        base_tick   = !reset && enable && (presc_q == PRESC_LAST);
        presc_d     = presc_q;
        if (enable) begin
            presc_d = base_tick ? '0 : presc_q + PW'(1);
        end
        cfg_fire    = cfg.cfg_valid && cfg_ready_q;
        cfg_ready_d = !cfg_fire;
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign tick_out      = tick_q;
`ifdef TICK_SCHED_TOGGLE_EN
    assign clk_out       = toggle_q;
`endif

    always_comb begin
        ch_active = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_active[i] = (state_q[i] == ST_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            cfg_ready_q <= 1'b1;
            oneshot_q   <= '0;
            tick_q      <= '0;
`ifdef TICK_SCHED_TOGGLE_EN
            toggle_q    <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            presc_q     <= presc_d;
            cfg_ready_q <= cfg_ready_d;
            for (int i = 0; i < NUM_CH; i++) begin
                tick_q[i] <= 1'b0;
                // A write to this channel overrides any base_tick in the same cycle.
                if (cfg_fire && (cfg.cfg_ch == 3'(i))) begin
                    if (cfg.cfg_start && (cfg.cfg_period != '0)) begin
                        state_q[i]   <= ST_RUN;
                        period_q[i]  <= cfg.cfg_period;
                        oneshot_q[i] <= cfg.cfg_oneshot;
                        cnt_q[i]     <= cfg.cfg_period - CNT_W'(1);
                    end else begin
                        state_q[i] <= ST_IDLE;
                        cnt_q[i]   <= '0;
`ifdef TICK_SCHED_TOGGLE_EN
                        toggle_q[i] <= 1'b0;
`endif
                    end
                end else if ((state_q[i] == ST_RUN) && base_tick) begin
                    if (cnt_q[i] != '0) begin
                        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                    end else begin
                        tick_q[i] <= 1'b1;
`ifdef TICK_SCHED_TOGGLE_EN
                        toggle_q[i] <= ~toggle_q[i];
`endif
                        if (oneshot_q[i]) begin
                            state_q[i] <= ST_IDLE;
                        end else begin
                            cnt_q[i] <= period_q[i] - CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: per-scenario tasks compared every cycle against an arithmetic reference model.
module tb_tick_scheduler;

    localparam int P = 4;
    localparam int N = 4;
    localparam int W = 8;
`ifdef TICK_SCHED_TOGGLE_EN
    localparam int VW = 2 + 3 * N;
`else
    localparam int VW = 2 + 2 * N;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic base_tick;
    logic [N-1:0] ch_active;
    logic [N-1:0] tick_out;
`ifdef TICK_SCHED_TOGGLE_EN
    logic [N-1:0] clk_out;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tick_scheduler_if #(.CNT_W(W)) cfg ();

    tick_scheduler #(.PRESCALE(P), .NUM_CH(N), .CNT_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg       (cfg),
        .base_tick (base_tick),
        .ch_active (ch_active),
        .tick_out  (tick_out)
`ifdef TICK_SCHED_TOGGLE_EN
        ,
        .clk_out   (clk_out)
`endif
    );

    // Reference model: a channel started at base-tick count S with period N fires
    // on base ticks S+N, S+2N, ... (only the first for one-shot); tick_out follows a cycle later.
    int           m_en;
    int           m_bt;
    logic         m_acc;
    logic [N-1:0] m_run, m_tick, m_one, m_clk;
    int           m_sbt [N];
    int           m_per [N];

    function automatic logic m_bt_now();
        return !reset && enable && ((m_en % P) == (P - 1));
    endfunction

    function automatic logic [VW-1:0] exp_vec();
`ifdef TICK_SCHED_TOGGLE_EN
        return {m_bt_now(), ~m_acc, m_run, m_tick, m_clk};
`else
        return {m_bt_now(), ~m_acc, m_run, m_tick};
`endif
    endfunction

    logic [VW-1:0] obs;
`ifdef TICK_SCHED_TOGGLE_EN
    assign obs = {base_tick, cfg.cfg_ready, ch_active, tick_out, clk_out};
`else
    assign obs = {base_tick, cfg.cfg_ready, ch_active, tick_out};
`endif

    always @(posedge clk) begin
        logic bt, acc;
        if (reset) begin
            m_en = 0; m_bt = 0; m_acc = 1'b0;
            m_run = '0; m_tick = '0; m_one = '0; m_clk = '0;
            for (int i = 0; i < N; i++) begin
                m_sbt[i] = 0; m_per[i] = 0;
            end
        end else begin
            bt  = m_bt_now();
            acc = cfg.cfg_valid && !m_acc;
            for (int i = 0; i < N; i++) begin
                m_tick[i] = 1'b0;
                if (acc && (int'(cfg.cfg_ch) == i)) begin
                    if (cfg.cfg_start && (cfg.cfg_period != 0)) begin
                        m_run[i] = 1'b1;
                        m_sbt[i] = m_bt + int'(bt);
                        m_per[i] = int'(cfg.cfg_period);
                        m_one[i] = cfg.cfg_oneshot;
                    end else begin
                        m_run[i] = 1'b0;
                        m_clk[i] = 1'b0;
                    end
                end else if (m_run[i] && bt && (((m_bt + 1 - m_sbt[i]) % m_per[i]) == 0)) begin
                    m_tick[i] = 1'b1;
                    m_clk[i]  = ~m_clk[i];
                    if (m_one[i]) m_run[i] = 1'b0;
                end
            end
            m_bt  = m_bt + int'(bt);
            m_en  = m_en + int'(enable);
            m_acc = acc;
        end
    end

    task automatic set_cfg(input logic v, input int ch, input int per, input logic one, input logic st);
        cfg.cfg_valid   = v;
        cfg.cfg_ch      = 3'(ch);
        cfg.cfg_period  = W'(per);
        cfg.cfg_oneshot = one;
        cfg.cfg_start   = st;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        set_cfg(1'b0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", obs, exp_vec());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL reset_idle c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            total++;
            if (base_tick !== ((c % P) == 0)) begin
                bad++; $display("FAIL reset_base_tick c=%0d got=%b exp=%b", c, base_tick, ((c % P) == 0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_periodic();
        int last, pulses;
        last = -1; pulses = 0;
        set_cfg(1'b1, 0, 3, 1'b0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL periodic c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            if (c == 1) begin
                total++;
                if ({cfg.cfg_ready, ch_active[0]} !== 2'b01) begin
                    bad++; $display("FAIL periodic_ready_low got=%b exp=01", {cfg.cfg_ready, ch_active[0]});
                end
            end
            if (c == 2) begin
                total++;
                if (cfg.cfg_ready !== 1'b1) begin
                    bad++; $display("FAIL periodic_ready_back got=%b exp=1", cfg.cfg_ready);
                end
            end
            if (tick_out[0] === 1'b1) begin
                if (last >= 0) begin
                    total++;
                    if (c - last != 3 * P) begin
                        bad++; $display("FAIL periodic_spacing got=%0d exp=%0d", c - last, 3 * P);
                    end
                end
                last = c; pulses++;
            end
            @(posedge clk); #1;
            cfg.cfg_valid = 1'b0;
        end
        total++;
        if (pulses < 3) begin
            bad++; $display("FAIL periodic_count got=%0d exp>=3", pulses);
        end
    endtask

    task automatic test_oneshot();
        int bts, fire_c, pulses;
        bts = 0; fire_c = -1; pulses = 0;
        set_cfg(1'b1, 1, 2, 1'b1, 1'b1);
        for (int c = 0; c < 30; c++) begin
            if (c >= 1 && m_bt_now()) begin
                bts++;
                if (bts == 2) fire_c = c;
            end
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL oneshot c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            if (tick_out[1] === 1'b1) begin
                pulses++;
                total++;
                if (c != fire_c + 1) begin
                    bad++; $display("FAIL oneshot_latency got=%0d exp=%0d", c, fire_c + 1);
                end
            end
            @(posedge clk); #1;
            cfg.cfg_valid = 1'b0;
        end
        total++;
        if ({pulses == 1, ch_active[1]} !== 2'b10) begin
            bad++; $display("FAIL oneshot_single got=%0d pulses active=%b exp=1 pulse active=0", pulses, ch_active[1]);
        end
    endtask

    task automatic test_restart();
        int w;
        w = -1;
        for (int c = 0; c < 60; c++) begin
            if (w < 0 && c < 40 && m_run[0] && !m_acc && m_bt_now() &&
                (((m_bt + 1 - m_sbt[0]) % m_per[0]) == 0)) begin
                w = c;
                set_cfg(1'b1, 0, 3, 1'b0, 1'b1);
            end
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL restart c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            if (w >= 0 && c > w) begin
                total++;
                if (tick_out[0] !== (c == w + 3 * P + 1)) begin
                    bad++; $display("FAIL restart_pulse c=%0d got=%b exp=%b", c - w, tick_out[0], (c == w + 3 * P + 1));
                end
            end
            @(posedge clk); #1;
            cfg.cfg_valid = 1'b0;
            if (w >= 0 && c >= w + 3 * P + 2) break;
        end
        if (w < 0) begin
            total++; bad++;
            $display("FAIL restart_align got=none exp=fire-aligned base_tick within 40 cycles");
        end
    endtask

    task automatic test_invalid_b2b();
        set_cfg(1'b1, 2, 0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL b2b c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            if (c >= 1 && c <= 3) begin
                total++;
                if (cfg.cfg_ready !== (c == 2)) begin
                    bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, cfg.cfg_ready, (c == 2));
                end
            end
            if (c == 7) begin
                total++;
                if (ch_active[3:1] !== 3'b000) begin
                    bad++; $display("FAIL invalid_no_effect got=%b exp=000", ch_active[3:1]);
                end
            end
            @(posedge clk); #1;
            if (c == 0) set_cfg(1'b1, 5, 7, 1'b0, 1'b1);
            if (c == 2) cfg.cfg_valid = 1'b0;
        end
    endtask

    task automatic test_enable_hold();
        int p1;
        p1 = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL hold c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            if (p1 >= 0 && c > p1) begin
                total++;
                if (tick_out[0] !== (c == p1 + 3 * P + 10)) begin
                    bad++; $display("FAIL hold_delay c=%0d got=%b exp=%b", c - p1, tick_out[0], (c == p1 + 3 * P + 10));
                end
            end
            if (p1 < 0 && tick_out[0] === 1'b1) p1 = c;
            @(posedge clk); #1;
            enable = !(p1 >= 0 && c >= p1 && c < p1 + 10);
            if (p1 >= 0 && c == p1 + 2) set_cfg(1'b1, 3, 4, 1'b0, 1'b1);
            else cfg.cfg_valid = 1'b0;
            if (p1 >= 0 && c >= p1 + 3 * P + 12) break;
        end
        if (p1 < 0) begin
            total++; bad++;
            $display("FAIL hold_pulse got=none exp=tick_out[0] within 80 cycles");
        end
        enable = 1'b1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL midreset c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            if (c >= 1) begin
                total++;
                if ({base_tick, ch_active, tick_out} !== '0) begin
                    bad++; $display("FAIL midreset_clear c=%0d got=%b exp=0", c, {base_tick, ch_active, tick_out});
                end
            end
            @(posedge clk); #1;
            if (c == 1) reset = 1'b0;
        end
    endtask

`ifdef TICK_SCHED_TOGGLE_EN
    task automatic test_toggle();
        int last, edges;
        logic prev;
        last = -1; edges = 0; prev = 1'b0;
        set_cfg(1'b1, 0, 3, 1'b0, 1'b1);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL toggle c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            if (clk_out[0] !== prev) begin
                if (last >= 0) begin
                    total++;
                    if (c - last != 3 * P) begin
                        bad++; $display("FAIL toggle_half_period got=%0d exp=%0d", c - last, 3 * P);
                    end
                end
                last = c; edges++; prev = clk_out[0];
            end
            @(posedge clk); #1;
            cfg.cfg_valid = 1'b0;
        end
        total++;
        if (edges < 4) begin
            bad++; $display("FAIL toggle_edges got=%0d exp>=4", edges);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (!cfg.cfg_valid && $urandom_range(0, 3) == 0) begin
                set_cfg(1'b1, int'($urandom_range(0, 7)),
                        ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4)),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
            end
            enable = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random c=%0d got=%b exp=%b", c, obs, exp_vec());
            end
            @(posedge clk); #1;
            if (m_acc) cfg.cfg_valid = 1'b0;
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_restart();
        test_invalid_b2b();
        test_enable_hold();
`ifdef TICK_SCHED_TOGGLE_EN
        test_toggle();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
